// File: rtl/conv_chnl_scheduler_if.sv
// Handshake bundle between the convolution channel scheduler (slave) and its environment:
// the layer controller, the weight buffer, the pixel source and the window counter group (master).
interface conv_chnl_scheduler_if #(parameter int CH_W = 10);
  logic            start;
  logic            abort;
  logic [CH_W-1:0] cfg_in_ch;
  logic [CH_W-1:0] cfg_out_ch;
  logic            wgt_req;
  logic [CH_W-1:0] wgt_ic;
  logic [CH_W-1:0] wgt_oc;
  logic            wgt_ack;
  logic            pix_avail;
  logic            feed_valid;
  logic            chnl_done_i;
  logic            acc_first;
  logic            psum_commit;
  logic            busy;
  logic            layer_done;

  modport master (
    output start, abort, cfg_in_ch, cfg_out_ch, wgt_ack, pix_avail, chnl_done_i,
    input  wgt_req, wgt_ic, wgt_oc, feed_valid, acc_first, psum_commit, busy, layer_done
  );

  modport slave (
    input  start, abort, cfg_in_ch, cfg_out_ch, wgt_ack, pix_avail, chnl_done_i,
    output wgt_req, wgt_ic, wgt_oc, feed_valid, acc_first, psum_commit, busy, layer_done
  );
endinterface

// File: rtl/conv_chnl_scheduler.sv
// Walks a conv layer channel-pair by channel-pair: load a 3x3 kernel, stream one plane,
// flush the pipeline, then advance ic (inner) / oc (outer) and commit finished output planes.
module conv_chnl_scheduler #(
  parameter int DRAIN_CYC = 4,
  parameter int CH_W      = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_chnl_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] ic_q, ic_d, oc_q, oc_d;
  logic [CH_W-1:0] in_ch_q, in_ch_d, out_ch_q, out_ch_d;
  logic [3:0]      drain_q, drain_d;
  logic            psum_commit_c, layer_done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ic_q     <= '0;
      oc_q     <= '0;
      in_ch_q  <= '0;
      out_ch_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      ic_q     <= ic_d;
      oc_q     <= oc_d;
      in_ch_q  <= in_ch_d;
      out_ch_q <= out_ch_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ic_d          = ic_q;
    oc_d          = oc_q;
    in_ch_d       = in_ch_q;
    out_ch_d      = out_ch_q;
    drain_d       = drain_q;
    psum_commit_c = 1'b0;
    layer_done_c  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        // a zero channel count is run as a single channel
        in_ch_d  = (bus.cfg_in_ch  == '0) ? CH_W'(1) : bus.cfg_in_ch;
        out_ch_d = (bus.cfg_out_ch == '0) ? CH_W'(1) : bus.cfg_out_ch;
        ic_d     = '0;
        oc_d     = '0;
        state_d  = LOAD_W;
      end
      LOAD_W: if (bus.wgt_ack) state_d = STREAM;
      STREAM: if (bus.chnl_done_i) begin
        drain_d = 4'(DRAIN_CYC - 1);
        state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q != '0) begin
          drain_d = drain_q - 4'd1;
        end else if (ic_q < in_ch_q - CH_W'(1)) begin
          ic_d    = ic_q + CH_W'(1);
          state_d = LOAD_W;
        end else begin
          // oc_q is still the finished plane this cycle, so wgt_oc tags the commit
          psum_commit_c = 1'b1;
          if (oc_q < out_ch_q - CH_W'(1)) begin
            ic_d    = '0;
            oc_d    = oc_q + CH_W'(1);
            state_d = LOAD_W;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        layer_done_c = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d       = IDLE;
      ic_d          = '0;
      oc_d          = '0;
      drain_d       = '0;
      psum_commit_c = 1'b0;
      layer_done_c  = 1'b0;
    end
  end

  assign bus.wgt_req     = (state_q == LOAD_W);
  assign bus.wgt_ic      = ic_q;
  assign bus.wgt_oc      = oc_q;
  assign bus.feed_valid  = (state_q == STREAM) && bus.pix_avail;
  assign bus.acc_first   = (state_q == STREAM) && (ic_q == '0);
  assign bus.psum_commit = psum_commit_c;
  assign bus.busy        = (state_q != IDLE);
  assign bus.layer_done  = layer_done_c;

endmodule

// File: tb/tb_conv_chnl_scheduler.sv
// Randomized bench: the expected kernel-load order, commit points and layer_done are
// derived from the channel loop nest (oc outer, ic inner) and compared cycle by cycle.
module tb_conv_chnl_scheduler;
  localparam int CH_W = 10;
  localparam int DC   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_chnl_scheduler_if #(.CH_W(CH_W)) bus ();
  conv_chnl_scheduler #(.DRAIN_CYC(DC), .CH_W(CH_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_in_ch = '0; bus.cfg_out_ch = '0;
    bus.wgt_ack = 1'b0; bus.pix_avail = 1'b0; bus.chnl_done_i = 1'b0;
  endtask

  task automatic quiet(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_pc"},   32'(bus.psum_commit), 0);
      chk({tag, "_ld"},   32'(bus.layer_done), 0);
      step();
    end
  endtask

  // ack_dly / slen < 0 select random values
  task automatic run_layer(input int cin, input int cout, input int ack_dly, input int slen,
                           input bit do_abort);
    int ni, no, loads, commits, d, n;
    int exp_ic[$];
    int exp_oc[$];
    bit exp_pc;
    ni = (cin == 0) ? 1 : cin;
    no = (cout == 0) ? 1 : cout;
    for (int o = 0; o < no; o++)
      for (int i = 0; i < ni; i++) begin
        exp_ic.push_back(i);
        exp_oc.push_back(o);
      end
    loads = 0; commits = 0;
    bus.cfg_in_ch = CH_W'(cin); bus.cfg_out_ch = CH_W'(cout); bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.cfg_in_ch = '1; bus.cfg_out_ch = '1;
    chk("busy_start", 32'(bus.busy), 1);
    for (int e = 0; e < exp_ic.size(); e++) begin
      d = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
      for (int k = 0; k < d; k++) begin
        bus.pix_avail = 1'($urandom);
        bus.chnl_done_i = (k == 0);
        #1;
        chk("ld_req", 32'(bus.wgt_req), 1);
        chk("ld_ic",  32'(bus.wgt_ic), 32'(exp_ic[e]));
        chk("ld_oc",  32'(bus.wgt_oc), 32'(exp_oc[e]));
        chk("ld_feed", 32'(bus.feed_valid), 0);
        step();
        bus.chnl_done_i = 1'b0;
      end
      bus.wgt_ack = 1'b1;
      #1;
      chk("ack_req", 32'(bus.wgt_req), 1);
      chk("ack_ic",  32'(bus.wgt_ic), 32'(exp_ic[e]));
      chk("ack_oc",  32'(bus.wgt_oc), 32'(exp_oc[e]));
      if (bus.wgt_req) loads++;
      step();
      bus.wgt_ack = 1'b0;
      n = (slen < 0) ? int'($urandom_range(1, 8)) : slen;
      for (int k = 0; k <= n; k++) begin
        bus.pix_avail = 1'($urandom);
        bus.wgt_ack = (k == 0);
        bus.start = (k == 1);
        bus.chnl_done_i = (k == n);
        #1;
        chk("st_feed", 32'(bus.feed_valid), 32'(bus.pix_avail));
        chk("st_accf", 32'(bus.acc_first), 32'(exp_ic[e] == 0));
        chk("st_req",  32'(bus.wgt_req), 0);
        step();
      end
      bus.wgt_ack = 1'b0; bus.start = 1'b0; bus.chnl_done_i = 1'b0;
      bus.pix_avail = 1'b1;
      for (int k = 0; k < DC; k++) begin
        exp_pc = (k == DC - 1) && (exp_ic[e] == ni - 1);
        if (do_abort && (e == exp_ic.size() - 1) && (k == DC - 1)) begin
          bus.abort = 1'b1;
          #1;
          chk("ab_pc", 32'(bus.psum_commit), 0);
          chk("ab_ld", 32'(bus.layer_done), 0);
          step();
          bus.abort = 1'b0;
          chk("ab_idle", 32'(bus.busy), 0);
          chk("ab_ic", 32'(bus.wgt_ic), 0);
          chk("ab_oc", 32'(bus.wgt_oc), 0);
          quiet(3, "ab_after");
          chk("ab_loads", 32'(loads), 32'(ni * no));
          chk("ab_commits", 32'(commits), 32'(no - 1));
          bus.pix_avail = 1'b0;
          return;
        end
        #1;
        chk("dr_feed", 32'(bus.feed_valid), 0);
        chk("dr_busy", 32'(bus.busy), 1);
        chk("dr_pc", 32'(bus.psum_commit), 32'(exp_pc));
        if (bus.psum_commit) begin
          commits++;
          chk("pc_oc", 32'(bus.wgt_oc), 32'(exp_oc[e]));
        end
        step();
      end
      bus.pix_avail = 1'b0;
    end
    chk("done_pulse", 32'(bus.layer_done), 1);
    step();
    chk("done_clr", 32'(bus.layer_done), 0);
    chk("done_idle", 32'(bus.busy), 0);
    chk("loads", 32'(loads), 32'(ni * no));
    chk("commits", 32'(commits), 32'(no));
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    bus.pix_avail = 1'b1;
    step(); step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_req",  32'(bus.wgt_req), 0);
    chk("rst_feed", 32'(bus.feed_valid), 0);
    chk("rst_pc",   32'(bus.psum_commit), 0);
    chk("rst_ld",   32'(bus.layer_done), 0);
    chk("rst_ic",   32'(bus.wgt_ic), 0);
    chk("rst_accf", 32'(bus.acc_first), 0);
    bus.pix_avail = 1'b0;
    rst_n = 1'b1;
    step();

    run_layer(2, 2, 3, 10, 1'b0);
    quiet(2, "gap");
    run_layer(0, 0, -1, -1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      run_layer(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), -1, -1, 1'b0);
      quiet(1, "gap");
    end
    run_layer(2, 1, -1, -1, 1'b1);
    run_layer(1, 3, -1, -1, 1'b1);

    // reset in the middle of a plane stream
    bus.cfg_in_ch = CH_W'(2); bus.cfg_out_ch = CH_W'(2); bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.wgt_ack = 1'b1;
    step();
    bus.wgt_ack = 1'b0; bus.pix_avail = 1'b1;
    step();
    chk("mr_feed_pre", 32'(bus.feed_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_feed", 32'(bus.feed_valid), 0);
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_accf", 32'(bus.acc_first), 0);
    chk("mr_req",  32'(bus.wgt_req), 0);
    step(); step();
    bus.pix_avail = 1'b0;
    rst_n = 1'b1;
    step();
    quiet(3, "mr_after");
    run_layer(3, 2, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
